// File: rtl/instr_fetch.sv
// Instruction fetch stage: in-order word reads into a small {pc,instr} FIFO feeding decode.
// Requests are credited so buffered + outstanding never exceeds DEPTH; redirects flush and refetch.
module instr_fetch #(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0,
  parameter int unsigned      DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [6:0]      id_opcode
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  // Handshake: a transfer happens on a rising edge where valid && ready; valid never
  // depends on ready, and a pending request only drops when a redirect withdraws it.

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   out_live_q, out_live_d;
  logic [CW-1:0]   out_drop_q, out_drop_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [XLEN-1:0] fifo_pc_q    [DEPTH];
  logic [XLEN-1:0] fifo_instr_q [DEPTH];

  logic [CW+1:0] inflight;
  logic          req_fire;
  logic          push;
  logic          pop;
  logic          unused_ok;

  assign unused_ok = ^redirect_pc[1:0];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign inflight = {2'b00, cnt_q} + {2'b00, out_live_q} + {2'b00, out_drop_q};

  assign imem_req_valid = !rst && !redirect_valid && (inflight < (CW+2)'(DEPTH));
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign id_valid  = (cnt_q != '0) && !redirect_valid;
  assign id_instr  = (cnt_q != '0) ? fifo_instr_q[rd_ptr_q] : NOP;
  assign id_pc     = (cnt_q != '0) ? fifo_pc_q[rd_ptr_q] : '0;
  assign id_opcode = id_instr[6:0];
  assign pop       = id_valid && id_ready;

  // Responses owed to a squashed path are retired first; the redirect cycle discards too.
  assign push = imem_rsp_valid && (out_drop_q == '0) && !redirect_valid;

  always_comb begin
    pc_d       = pc_q;
    rsp_pc_d   = rsp_pc_q;
    cnt_d      = cnt_q;
    out_live_d = out_live_q;
    out_drop_d = out_drop_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (redirect_valid) begin
      pc_d       = {redirect_pc[XLEN-1:2], 2'b00};
      rsp_pc_d   = {redirect_pc[XLEN-1:2], 2'b00};
      cnt_d      = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      out_live_d = '0;
      out_drop_d = out_drop_q + out_live_q - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) pc_d = pc_q + XLEN'(4);
      if (push) begin
        rsp_pc_d = rsp_pc_q + XLEN'(4);
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      cnt_d      = cnt_q + CW'(push) - CW'(pop);
      out_live_d = out_live_q + CW'(req_fire) - CW'(push);
      if (imem_rsp_valid && (out_drop_q != '0)) out_drop_d = out_drop_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      cnt_q      <= '0;
      out_live_q <= '0;
      out_drop_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      rsp_pc_q   <= rsp_pc_d;
      cnt_q      <= cnt_d;
      out_live_q <= out_live_d;
      out_drop_q <= out_drop_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage needs no reset: cnt_q gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]    <= rsp_pc_q;
      fifo_instr_q[wr_ptr_q] <= imem_rsp_data;
    end
  end

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (cnt_q == CW'(DEPTH))));
  a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
    !(imem_rsp_valid && (out_live_q == '0) && (out_drop_q == '0)));
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch: a memory model with in-order random latency,
// an architectural stream model (sequential PCs, flushed by redirect/reset) and a scoreboard.
module tb_instr_fetch;
  localparam int DEPTH = 2;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [6:0]  id_opcode;

  instr_fetch #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_instr(id_instr), .id_pc(id_pc), .id_opcode(id_opcode)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } mreq_t;

  mreq_t       mem_q[$];
  logic [63:0] exp_q[$];
  logic [31:0] model_pc;
  int          epoch;
  int          cyc;
  int          last_due;
  int          first_valid;
  int          n_cmp;
  int          n_fail;

  int          p_ready, p_idr, p_redir, lat_min, lat_max;
  logic        fixed_tgt;
  logic [31:0] fixed_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst            = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b0;
    #1;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_id_valid", id_valid, 0);
    chk("rst_id_instr", id_instr, 32'h13);
    chk("rst_id_pc", id_pc, 0);
    chk("rst_id_opcode", id_opcode, 7'h13);
    mem_q.delete();
    exp_q.delete();
    model_pc = 32'h0;
    last_due = -1;
    epoch++;
    repeat (2) @(posedge clk);
    #1;
    rst         = 1'b0;
    cyc         = 0;
    first_valid = -1;
  endtask

  task automatic cycle();
    int   live_out;
    int   buffered;
    int   lat;
    int   due;
    logic exp_rv;
    logic exp_idv;
    logic rsp_now;
    @(negedge clk);
    imem_req_ready = ($urandom_range(0, 99) < p_ready);
    id_ready       = ($urandom_range(0, 99) < p_idr);
    redirect_valid = ($urandom_range(0, 99) < p_redir);
    if (fixed_tgt) redirect_pc = fixed_pc;
    else if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | $urandom_range(0, 15);
    else redirect_pc = $urandom_range(0, 1023);
    rsp_now = 1'b0;
    if (mem_q.size() > 0) rsp_now = (mem_q[0].due <= cyc);
    imem_rsp_valid = rsp_now;
    imem_rsp_data  = rsp_now ? mem_word(mem_q[0].addr) : $urandom;
    #1;
    live_out = 0;
    foreach (mem_q[i]) if (mem_q[i].epoch == epoch) live_out++;
    buffered = exp_q.size() - live_out;
    exp_rv   = !redirect_valid && ((mem_q.size() + buffered) < DEPTH);
    exp_idv  = !redirect_valid && (buffered > 0);
    chk("req_valid", imem_req_valid, exp_rv);
    if (exp_rv) chk("req_addr", imem_req_addr, model_pc);
    chk("id_valid", id_valid, exp_idv);
    if (buffered == 0) begin
      chk("empty_instr", id_instr, 32'h13);
      chk("empty_pc", id_pc, 0);
      chk("empty_opcode", id_opcode, 7'h13);
    end
    if (id_valid && first_valid < 0) first_valid = cyc;
    if (rsp_now) void'(mem_q.pop_front());
    if (redirect_valid) begin
      exp_q.delete();
      epoch++;
      model_pc = {redirect_pc[31:2], 2'b00};
    end else if (exp_rv && imem_req_ready) begin
      lat = $urandom_range(lat_min, lat_max);
      due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      last_due = due;
      mem_q.push_back('{addr: model_pc, epoch: epoch, due: due});
      exp_q.push_back({model_pc, mem_word(model_pc)});
      model_pc = model_pc + 32'd4;
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic knobs(input int r, input int idr, input int rd, input int lmin, input int lmax);
    p_ready = r; p_idr = idr; p_redir = rd; lat_min = lmin; lat_max = lmax;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [63:0] e;
    #2;
    if (!rst && id_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL id_unexpected: got pc %0h with nothing expected (cycle %0d)", id_pc, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("id_pc", id_pc, e[63:32]);
        chk("id_instr", id_instr, e[31:0]);
        chk("id_opcode", id_opcode, e[6:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_cmp = 0; n_fail = 0; epoch = 0; cyc = 0;
    fixed_tgt = 1'b0; fixed_pc = '0;
    knobs(100, 100, 0, 1, 1);
    do_reset();

    // Streaming with a 1-cycle memory
    run(20);
    chk("first_id_valid_cycle", first_valid, 2);

    // Decode stall then release
    knobs(100, 0, 0, 1, 1);
    run(6);
    knobs(100, 100, 0, 1, 1);
    run(10);

    // Redirect with two slow requests outstanding
    do_reset();
    knobs(100, 100, 0, 3, 3);
    run(2);
    fixed_tgt = 1'b1; fixed_pc = 32'h0000_0104;
    p_redir = 100;
    run(1);
    p_redir = 0; fixed_tgt = 1'b0;
    run(15);

    // Memory backpressure
    knobs(25, 100, 0, 1, 2);
    run(40);

    // Random mix including redirects and wrap-around targets
    knobs(70, 60, 8, 1, 4);
    run(2000);

    // Asynchronous reset between edges with state in flight
    knobs(100, 0, 0, 1, 1);
    run(4);
    #2;
    do_reset();
    knobs(100, 100, 0, 1, 1);
    run(20);
    chk("first_id_valid_after_rst", first_valid, 2);

    knobs(60, 70, 5, 1, 3);
    run(1500);

    // Drain: no new requests, everything owed must arrive
    knobs(0, 100, 0, 1, 1);
    run(12);
    chk("drain_exp_q", exp_q.size(), 0);
    chk("drain_mem_q", mem_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
